// File: rtl/ad_scan_pkg.sv
// Shared constants and state encoding for the ADC scan controller and the ADC interface block.
package ad_scan_pkg;

    // Conversion window (cs_n low) in t_data ticks, shared with the ADC interface block
    localparam int AD_CONV_FIRST = 1;
    localparam int AD_CONV_LAST  = 700;
    localparam int AD_MIN_SLOT   = 720;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/ad_scan_ctrl_timer.sv
// Slot timebase for the scan controller: free-running t_data counter with
// clear/run controls and capture-tick / slot-end strobes.
module ad_slot_timer
    import ad_scan_pkg::*;
#(
    parameter int SLOT_TICKS   = 1000,
    parameter int CAPTURE_TICK = 704
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        run_i,
    output logic [15:0] t_data_o,
    output logic        cap_tick_o,
    output logic        slot_end_o
);

    localparam logic [15:0] LAST_T = 16'(SLOT_TICKS - 1);
    localparam logic [15:0] CAP_T  = 16'(CAPTURE_TICK);

    // volt is only stable two clocks after the window closes, and the mux needs tick 0 to settle
    if (SLOT_TICKS < AD_MIN_SLOT || CAPTURE_TICK < AD_CONV_LAST + 3 ||
        CAPTURE_TICK >= SLOT_TICKS || AD_CONV_FIRST < 1) begin : g_bad_timing
        $error("ad_slot_timer: illegal SLOT_TICKS/CAPTURE_TICK combination");
    end

    logic [15:0] t_q;

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            t_q <= '0;
        end else if (run_i) begin
            t_q <= (t_q == LAST_T) ? '0 : t_q + 16'd1;
        end
    end

    assign t_data_o   = t_q;
    assign cap_tick_o = run_i && (t_q == CAP_T);
    assign slot_end_o = run_i && (t_q == LAST_T);

endmodule

// File: rtl/ad_scan_ctrl.sv
// Multi-channel ADC scan controller: sequences the analog mux, times each conversion slot
// and emits one tagged result per channel. Define AD_SCAN_AVG_EN for 4-slot averaging.
module ad_scan_ctrl
    import ad_scan_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 2,
    parameter int SLOT_TICKS   = 1000,
    parameter int CAPTURE_TICK = 704
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            cont,
    input  logic [15:0]     volt,
    output logic [15:0]     t_data,
    output logic [CH_W-1:0] mux_sel,
    output logic            busy,
    output logic            res_valid,
    output logic [CH_W-1:0] res_ch,
    output logic [15:0]     res_data,
    output logic            scan_done
);

    if (NUM_CH < 2 || NUM_CH > 16 || (2 ** CH_W) < NUM_CH) begin : g_bad_cfg
        $error("ad_scan_ctrl: NUM_CH must be 2..16 and fit in CH_W bits");
    end

    scan_state_e     state_q;
    logic [CH_W-1:0] ch_q;
    logic            cont_q;
    logic            res_valid_q;
    logic [CH_W-1:0] res_ch_q;
    logic [15:0]     res_data_q;
    logic            scan_done_q;

    logic            cap_tick;
    logic            slot_end;
    logic            last_ch;
    logic            slot_adv;
    logic            res_fire;
    logic [15:0]     res_value;

    ad_slot_timer #(
        .SLOT_TICKS  (SLOT_TICKS),
        .CAPTURE_TICK(CAPTURE_TICK)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   ((state_q == ST_IDLE) || stop),
        .run_i     (state_q == ST_RUN),
        .t_data_o  (t_data),
        .cap_tick_o(cap_tick),
        .slot_end_o(slot_end)
    );

    assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

`ifdef AD_SCAN_AVG_EN
    logic [1:0]  sub_q;
    logic [17:0] acc_q;
    logic [17:0] acc_d;

    // First slot of a channel starts a fresh sum instead of adding to the previous channel's
    assign acc_d     = ((sub_q == 2'd0) ? 18'd0 : acc_q) + 18'(volt);
    assign slot_adv  = slot_end && (sub_q == 2'd3);
    assign res_fire  = cap_tick && (sub_q == 2'd3);
    assign res_value = acc_d[17:2];
`else
    assign slot_adv  = slot_end;
    assign res_fire  = cap_tick;
    assign res_value = volt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            cont_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            scan_done_q <= 1'b0;
`ifdef AD_SCAN_AVG_EN
            sub_q       <= '0;
            acc_q       <= '0;
`endif
        end else begin
            res_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_q <= ST_RUN;
                        ch_q    <= '0;
                        cont_q  <= cont;
`ifdef AD_SCAN_AVG_EN
                        sub_q   <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // Abort wins over a coincident capture: the slot's result is dropped
                    if (stop) begin
                        state_q <= ST_IDLE;
                        ch_q    <= '0;
`ifdef AD_SCAN_AVG_EN
                        sub_q   <= '0;
                        acc_q   <= '0;
`endif
                    end else begin
                        if (res_fire) begin
                            res_valid_q <= 1'b1;
                            res_ch_q    <= ch_q;
                            res_data_q  <= res_value;
                        end
`ifdef AD_SCAN_AVG_EN
                        if (cap_tick) acc_q <= acc_d;
                        if (slot_end) sub_q <= sub_q + 2'd1;
`endif
                        if (slot_adv) begin
                            if (!last_ch) begin
                                ch_q <= ch_q + CH_W'(1);
                            end else begin
                                ch_q <= '0;
                                if (!cont_q) begin
                                    state_q     <= ST_IDLE;
                                    scan_done_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign mux_sel   = ch_q;
    assign busy      = (state_q == ST_RUN);
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_data  = res_data_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_ad_scan_ctrl.sv
// Scoreboard bench for ad_scan_ctrl: directed scans push expected results, a negedge
// monitor pops and compares each res_valid strobe. Define AD_SCAN_AVG_EN for the averaging case.
module tb_ad_scan_ctrl;

    localparam int CH_W = 2;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [15:0]     data;
        int              cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            cont = 1'b0;
    logic [15:0]     volt = 16'h0000;
    logic [15:0]     t_data;
    logic [CH_W-1:0] mux_sel;
    logic            busy;
    logic            res_valid;
    logic [CH_W-1:0] res_ch;
    logic [15:0]     res_data;
    logic            scan_done;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              n_done = 0;
    int              done_cyc = -1;
    int              n_mux_chg = 0;
    logic            prev_busy = 1'b0;
    logic [CH_W-1:0] prev_mux = '0;
    logic [15:0]     prev_t = '0;

    ad_scan_ctrl #(
        .NUM_CH      (4),
        .CH_W        (CH_W),
        .SLOT_TICKS  (1000),
        .CAPTURE_TICK(704)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .cont     (cont),
        .volt     (volt),
        .t_data   (t_data),
        .mux_sel  (mux_sel),
        .busy     (busy),
        .res_valid(res_valid),
        .res_ch   (res_ch),
        .res_data (res_data),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ADC interface model: result lands two clocks after the window closes, garbage while converting
`ifdef AD_SCAN_AVG_EN
    logic [15:0] avg_tab [4] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD};
    logic [1:0]  vcnt = '0;
`endif
    always @(negedge clk) begin
`ifdef AD_SCAN_AVG_EN
        if (!busy) vcnt = '0;
`endif
        if (t_data == 16'd1) begin
            volt = 16'hDEAD;
        end else if (t_data == 16'd702) begin
`ifdef AD_SCAN_AVG_EN
            volt = avg_tab[vcnt];
            vcnt = vcnt + 2'd1;
`else
            volt = 16'h1000 + 16'(mux_sel);
`endif
        end
    end

    // Monitor: result scoreboard, mux-change timing, scan_done bookkeeping
    always @(negedge clk) begin
        if (res_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got ch %0d data 0x%0h, expected none (cycle %0d)",
                         res_ch, res_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_ch", 32'(res_ch), 32'(e.ch));
                check("res_data", 32'(res_data), 32'(e.data));
                check("res_cycle", cyc, e.cyc);
            end
        end
        if (busy && prev_busy && (mux_sel != prev_mux)) begin
            n_mux_chg++;
            check("mux_chg_at_wrap", {prev_t == 16'd999, t_data == 16'd0}, 32'd3);
        end
        if (scan_done) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_busy = busy;
        prev_mux  = mux_sel;
        prev_t    = t_data;
    end

    task automatic pulse_start(input logic c, output int n0);
        start = 1'b1;
        cont  = c;
        @(negedge clk);
        start = 1'b0;
        n0 = cyc;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic push_exp(input int ch, input logic [15:0] data, input int at_cyc);
        sb.push_back('{ch: CH_W'(ch), data: data, cyc: at_cyc});
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check(name, sb.size(), 0);
    endtask

    task automatic wait_t(input string name, input int ch, input int t, input int budget);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (mux_sel == CH_W'(ch) && t_data == 16'(t)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(name, 32'(found), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_t_data"}, 32'(t_data), 32'd0);
        check({tag, "_mux_busy"}, {mux_sel, busy}, 32'd0);
        check({tag, "_res"}, {res_valid, res_ch, res_data}, 32'd0);
        check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    endtask

    initial begin
        int n0;
        int done_base;
        int mux_base;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

`ifdef AD_SCAN_AVG_EN
        // Averaging: four slots on channel 0, one averaged result, mux held
        mux_base = n_mux_chg;
        pulse_start(1'b0, n0);
        push_exp(0, 16'hFFFE, n0 + 3705);
        wait_sb_empty("avg_result", 4000);
        check("avg_mux_stable", n_mux_chg - mux_base, 0);
        check("avg_mux_sel", 32'(mux_sel), 32'd0);
        pulse_stop();
        check("avg_stop_busy", 32'(busy), 32'd0);
        done_base = n_done;
        check("avg_no_done", n_done - done_base, 0);
`else
        // Single scan: four results 1000 clocks apart, then scan_done
        done_base = n_done;
        pulse_start(1'b0, n0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_t0", 32'(t_data), 32'd0);
        @(negedge clk);
        check("start_t1", 32'(t_data), 32'd1);
        for (int k = 0; k < 4; k++) push_exp(k, 16'h1000 + 16'(k), n0 + 705 + 1000 * k);
        for (int i = 0; i < 4100; i++) begin
            if (n_done != done_base) break;
            @(negedge clk);
        end
        check("single_done_count", n_done - done_base, 1);
        check("single_done_cycle", done_cyc, n0 + 4000);
        check("single_results_left", sb.size(), 0);
        repeat (5) @(negedge clk);
        check("single_idle_t", 32'(t_data), 32'd0);
        check("single_idle_busy", {busy, scan_done}, 32'd0);

        // Continuous scan for 10 slots; a start with cont=0 mid-run must be ignored
        done_base = n_done;
        pulse_start(1'b1, n0);
        for (int k = 0; k < 10; k++) push_exp(k % 4, 16'h1000 + 16'(k % 4), n0 + 705 + 1000 * k);
        for (int i = 0; i < 10500; i++) begin
            if (sb.size() == 0) break;
            if (i == 1500) begin
                start = 1'b1;
                cont  = 1'b0;
            end else if (i == 1501) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("cont_results_left", sb.size(), 0);
        check("cont_no_done", n_done - done_base, 0);
        check("cont_still_busy", 32'(busy), 32'd1);
        pulse_stop();
        check("cont_stop_busy", 32'(busy), 32'd0);
        check("cont_stop_t", 32'(t_data), 32'd0);

        // Stop on the capture tick of channel 2: no ch2 result, no scan_done
        done_base = n_done;
        pulse_start(1'b0, n0);
        push_exp(0, 16'h1000, n0 + 705);
        push_exp(1, 16'h1001, n0 + 1705);
        wait_t("wait_ch2_cap", 2, 704, 3000);
        pulse_stop();
        check("stop_t", 32'(t_data), 32'd0);
        check("stop_mux_busy", {mux_sel, busy}, 32'd0);
        check("stop_no_valid", {res_valid, scan_done}, 32'd0);
        repeat (1200) @(negedge clk);
        check("stop_results_left", sb.size(), 0);
        check("stop_no_done", n_done - done_base, 0);

        // Reset mid-window on channel 1, then restart from channel 0
        pulse_start(1'b0, n0);
        push_exp(0, 16'h1000, n0 + 705);
        wait_t("wait_ch1_350", 1, 350, 2000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        pulse_start(1'b0, n0);
        push_exp(0, 16'h1000, n0 + 705);
        wait_sb_empty("restart_result", 800);
        check("restart_mux", 32'(mux_sel), 32'd0);
        pulse_stop();

        // start and stop together while idle
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("startstop_t", {t_data, busy}, 32'd0);
`endif

        repeat (20) @(negedge clk);
        check("final_results_left", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
